// File: rtl/spram_arbiter.sv
// Round-robin A/B arbiter plus post-reset zero-fill sweep in front of a single-port RAM.
// Grants are combinational (ready in the same cycle); read data returns one cycle after issue; losers hold.
module spram_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 64,
  parameter bit INIT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ready,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ready,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_me,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef enum logic {GNT_A, GNT_B} side_t;

  localparam logic [AW:0] LAST_ADDR = {1'b0, {AW{1'b1}}};
  localparam state_t      RST_STATE = INIT_EN ? ST_INIT : ST_RUN;

  state_t        state_q, state_d;
  side_t         last_q, last_d;
  logic [AW:0]   init_cnt_q, init_cnt_d;
  logic          init_done_q, init_done_d;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;
  logic          rd_pend_q, rd_pend_d;
  side_t         rd_owner_q, rd_owner_d;
  logic [DW-1:0] a_rdata_q, b_rdata_q;
  logic          gnt_a, gnt_b;

  // Every combinational output is gated by reset so nothing reaches the RAM
  // or the requesters while reset is held.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    ram_me      = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = ram_addr_q;
    ram_wdata   = ram_wdata_q;
    if (reset) begin
      case (state_q)
        ST_INIT: begin
          ram_me     = 1'b1;
          ram_wen    = 1'b1;
          ram_addr   = init_cnt_q[AW-1:0];
          ram_wdata  = '0;
          init_cnt_d = init_cnt_q + 1'b1;
          if (init_cnt_q == LAST_ADDR) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end
        end
        ST_RUN: begin
          gnt_a = a_req & (~b_req | (last_q == GNT_B));
          gnt_b = b_req & (~a_req | (last_q == GNT_A));
          if (gnt_a) begin
            last_d    = GNT_A;
            ram_me    = 1'b1;
            ram_wen   = a_we;
            ram_addr  = a_addr;
            ram_wdata = a_we ? a_wdata : '0;
          end else if (gnt_b) begin
            last_d    = GNT_B;
            ram_me    = 1'b1;
            ram_wen   = b_we;
            ram_addr  = b_addr;
            ram_wdata = b_we ? b_wdata : '0;
          end
        end
        default: state_d = RST_STATE;
      endcase
    end
  end

  assign a_ready    = gnt_a;
  assign b_ready    = gnt_b;
  assign rd_pend_d  = (gnt_a & ~a_we) | (gnt_b & ~b_we);
  assign rd_owner_d = gnt_b ? GNT_B : GNT_A;

  assign a_rvalid  = rd_pend_q & (rd_owner_q == GNT_A);
  assign b_rvalid  = rd_pend_q & (rd_owner_q == GNT_B);
  assign a_rdata   = a_rvalid ? ram_rdata : a_rdata_q;
  assign b_rdata   = b_rvalid ? ram_rdata : b_rdata_q;
  assign init_done = init_done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RST_STATE;
      last_q      <= GNT_B;
      init_cnt_q  <= '0;
      init_done_q <= ~INIT_EN;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= GNT_A;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      ram_addr_q  <= ram_addr;
      ram_wdata_q <= ram_wdata;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      a_rdata_q   <= a_rdata;
      b_rdata_q   <= b_rdata;
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter (AW=4) with a behavioural single-port RAM model.
module tb_spram_arbiter;
  localparam int AW = 4;
  localparam int DW = 64;
  localparam logic [DW-1:0] D1    = 64'hDEADBEEF_00000001;
  localparam logic [DW-1:0] D22   = 64'h0000_0000_0000_0022;
  localparam logic [DW-1:0] D1234 = 64'h0000_0000_0000_1234;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ready, a_rvalid, b_ready, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_me, ram_wen, init_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [DW-1:0] mem [2**AW];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spram_arbiter #(.AW(AW), .DW(DW), .INIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_me(ram_me), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .init_done(init_done)
  );

  // RAM model: write on enable+wen, registered read data otherwise
  always @(posedge clk) begin
    if (ram_me) begin
      if (ram_wen) mem[ram_addr] <= ram_wdata;
      else         ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wd;
    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wd;
    logic          e_ardy;
    logic          e_brdy;
    logic          e_arv;
    logic [DW-1:0] e_ard;
    logic          e_brv;
    logic [DW-1:0] e_brd;
    logic          e_me;
    logic          e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_me"}, 64'(ram_me), 64'd0);
    chk({tag, "_wen"}, 64'(ram_wen), 64'd0);
    chk({tag, "_addr"}, 64'(ram_addr), 64'd0);
    chk({tag, "_wdata"}, ram_wdata, 64'd0);
    chk({tag, "_rdy"}, 64'({a_ready, b_ready}), 64'd0);
    chk({tag, "_rv"}, 64'({a_rvalid, b_rvalid}), 64'd0);
    chk({tag, "_ard"}, a_rdata, 64'd0);
    chk({tag, "_brd"}, b_rdata, 64'd0);
    chk({tag, "_done"}, 64'(init_done), 64'd0);
  endtask

  initial begin
    //        a_req we ad  wd     b_req we ad wd     ardy brdy arv ard    brv brd    me wen ad wd
    tbl[0]  = '{1, 1, 3, D1,     0, 0, 0, 0,     1, 0, 0, 0,     0, 0,     1, 1, 3, D1};
    tbl[1]  = '{1, 0, 3, 0,      0, 0, 0, 0,     1, 0, 0, 0,     0, 0,     1, 0, 3, 0};
    tbl[2]  = '{0, 0, 0, 0,      0, 0, 0, 0,     0, 0, 1, D1,    0, 0,     0, 0, 3, 0};
    tbl[3]  = '{0, 0, 0, 0,      1, 1, 2, D22,   0, 1, 0, D1,    0, 0,     1, 1, 2, D22};
    tbl[4]  = '{1, 0, 1, 0,      1, 0, 2, 0,     1, 0, 0, D1,    0, 0,     1, 0, 1, 0};
    tbl[5]  = '{1, 0, 1, 0,      1, 0, 2, 0,     0, 1, 1, 0,     0, 0,     1, 0, 2, 0};
    tbl[6]  = '{1, 0, 1, 0,      1, 0, 2, 0,     1, 0, 0, 0,     1, D22,   1, 0, 1, 0};
    tbl[7]  = '{1, 0, 1, 0,      1, 0, 2, 0,     0, 1, 1, 0,     0, D22,   1, 0, 2, 0};
    tbl[8]  = '{1, 1, 5, D1234,  1, 0, 5, 0,     1, 0, 0, 0,     1, D22,   1, 1, 5, D1234};
    tbl[9]  = '{0, 0, 0, 0,      1, 0, 5, 0,     0, 1, 0, 0,     0, D22,   1, 0, 5, 0};
    tbl[10] = '{0, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 0,     1, D1234, 0, 0, 5, 0};
    tbl[11] = '{1, 0, 3, 0,      0, 0, 0, 0,     1, 0, 0, 0,     0, D1234, 1, 0, 3, 0};
    tbl[12] = '{1, 0, 5, 0,      1, 0, 3, 0,     0, 1, 1, D1,    0, D1234, 1, 0, 3, 0};
    tbl[13] = '{1, 0, 5, 0,      0, 0, 0, 0,     1, 0, 0, D1,    1, D1,    1, 0, 5, 0};
    tbl[14] = '{0, 0, 0, 0,      0, 0, 0, 0,     0, 0, 1, D1234, 0, D1,    0, 0, 5, 0};
    tbl[15] = '{0, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, D1234, 0, D1,    0, 0, 5, 0};

    // Garbage so the zero-fill is observable through later reads
    for (int i = 0; i < 2**AW; i++) mem[i] = 64'hA5A5_A5A5_A5A5_A5A5;
    ram_rdata = 64'hA5A5_A5A5_A5A5_A5A5;

    reset = 1'b0;
    idle_inputs();
    a_req = 1; b_req = 1;
    #2;
    chk_cleared("rst");
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 2**AW; i++) begin
      @(negedge clk);
      chk($sformatf("sweep%0d_me_wen", i), 64'({ram_me, ram_wen}), 64'd3);
      chk($sformatf("sweep%0d_addr", i), 64'(ram_addr), 64'(i));
      chk($sformatf("sweep%0d_wdata", i), ram_wdata, 64'd0);
      chk($sformatf("sweep%0d_rdy", i), 64'({a_ready, b_ready}), 64'd0);
      chk($sformatf("sweep%0d_done", i), 64'(init_done), 64'd0);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    chk("init_done_after_sweep", 64'(init_done), 64'd1);
    chk("idle_me_after_sweep", 64'(ram_me), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      a_req = tbl[i].a_req; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr; a_wdata = tbl[i].a_wd;
      b_req = tbl[i].b_req; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr; b_wdata = tbl[i].b_wd;
      @(negedge clk);
      chk($sformatf("v%0d_a_ready", i), 64'(a_ready), 64'(tbl[i].e_ardy));
      chk($sformatf("v%0d_b_ready", i), 64'(b_ready), 64'(tbl[i].e_brdy));
      chk($sformatf("v%0d_a_rvalid", i), 64'(a_rvalid), 64'(tbl[i].e_arv));
      chk($sformatf("v%0d_a_rdata", i), a_rdata, tbl[i].e_ard);
      chk($sformatf("v%0d_b_rvalid", i), 64'(b_rvalid), 64'(tbl[i].e_brv));
      chk($sformatf("v%0d_b_rdata", i), b_rdata, tbl[i].e_brd);
      chk($sformatf("v%0d_ram_me", i), 64'(ram_me), 64'(tbl[i].e_me));
      chk($sformatf("v%0d_ram_wen", i), 64'(ram_wen), 64'(tbl[i].e_wen));
      chk($sformatf("v%0d_ram_addr", i), 64'(ram_addr), 64'(tbl[i].e_addr));
      chk($sformatf("v%0d_ram_wdata", i), ram_wdata, tbl[i].e_wd);
      chk($sformatf("v%0d_init_done", i), 64'(init_done), 64'd1);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Reset with a read in flight
    a_req = 1; a_we = 0; a_addr = 4'd3;
    @(negedge clk);
    chk("inflight_a_ready", 64'(a_ready), 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    chk("inflight_rvalid_before_reset", 64'(a_rvalid), 64'd1);
    chk("inflight_rdata_before_reset", a_rdata, D1);
    reset = 1'b0;
    #1;
    chk_cleared("inflight_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("restart_addr", 64'(ram_addr), 64'd0);
    chk("restart_me_wen", 64'({ram_me, ram_wen}), 64'd3);
    chk("restart_no_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);

    // Reset mid-sweep at init_cnt=7
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("midsweep_addr7", 64'(ram_addr), 64'd7);
    #2;
    reset = 1'b0;
    #1;
    chk_cleared("midsweep_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midsweep_restart_addr", 64'(ram_addr), 64'd0);
    chk("midsweep_restart_me_wen", 64'({ram_me, ram_wen}), 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midsweep_restart_addr1", 64'(ram_addr), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
